seg7_reader: RTL

Recovers hex digits from the active-low 7-segment patterns our hex display decoder drives, i.e. it runs the segment encoding in reverse. It samples a multiplexed segment bus (pattern plus digit select) on a strobe and filters each digit for stability. Each newly stable digit value is reported over a valid/ready event port, and the current values are kept in a flat register. It sits next to the display path and lets the board checker and testbenches read back what is really shown on HEX0..HEX3.

---
 rtl/seg7_reader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seg7_reader.sv
// seg7_reader: recovers hex digits from muxed active-low 7-segment patterns, stability-filtered, reported as valid/ready events.
// Define SEG7_READER_BLANK_EN to accept 7F (all segments off) as a blank symbol.
module seg7_reader #(
  parameter int STABLE_CNT = 3,
  parameter int NUM_DIGITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_in,
  input  logic [1:0]  dig_sel,
  input  logic        sample,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_digit,
  output logic [3:0]  out_nibble,
  output logic        out_blank,
  output logic [15:0] digits_flat,
  output logic        err_pulse,
  output logic [7:0]  err_count
);
  localparam logic [3:0] SC = 4'(STABLE_CNT);

  logic [6:0] r_seg;
  logic [1:0] r_sel;
  logic       r_smp;
  logic [4:0] r_cand [NUM_DIGITS];
  logic [3:0] r_run  [NUM_DIGITS];
  logic [4:0] r_comm [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_cval, r_known, r_pend;
  logic       r_ovalid, r_oblank, r_err;
  logic [1:0] r_odig;
  logic [3:0] r_onib;
  logic [7:0] r_ecnt;

  logic [5:0] w_dec;
  logic       w_ok, w_hit, w_same, w_known, w_commit, w_err, w_load;
  logic [4:0] w_code, w_comm, w_lcode;
  logic [3:0] w_cur, w_run;
  logic [1:0] w_idx;
  logic [NUM_DIGITS-1:0] w_launch, w_cvec;
  logic [15:0] w_flat;

  // code = {blank, nibble}; bit 5 of the result flags a legal pattern
  function automatic logic [5:0] dec(input logic [6:0] s);
    case (s)
      7'h40: dec = 6'h20;
      7'h79: dec = 6'h21;
      7'h24: dec = 6'h22;
      7'h30: dec = 6'h23;
      7'h19: dec = 6'h24;
      7'h12: dec = 6'h25;
      7'h02: dec = 6'h26;
      7'h78: dec = 6'h27;
      7'h00: dec = 6'h28;
      7'h10: dec = 6'h29;
      7'h08: dec = 6'h2a;
      7'h03: dec = 6'h2b;
      7'h46: dec = 6'h2c;
      7'h21: dec = 6'h2d;
      7'h06: dec = 6'h2e;
      7'h0e: dec = 6'h2f;
`ifdef SEG7_READER_BLANK_EN
      7'h7f: dec = 6'h30;
`endif
      default: dec = 6'h00;
    endcase
  endfunction

  always_comb begin
    w_dec = dec(r_seg);
    w_ok = w_dec[5];
    w_code = w_dec[4:0];
    w_hit = r_smp && (int'(r_sel) < NUM_DIGITS);
    w_same = 1'b0;
    w_cur = 4'd0;
    w_known = 1'b0;
    w_comm = 5'd0;
    w_idx = 2'd0;
    w_lcode = 5'd0;
    w_flat = 16'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_sel == 2'(i)) begin
        w_same = r_cval[i] && r_cand[i] == w_code;
        w_cur = r_run[i];
        w_known = r_known[i];
        w_comm = r_comm[i];
      end
      w_flat[4*i +: 4] = r_comm[i][3:0];
    end
    for (int i = NUM_DIGITS - 1; i >= 0; i--)
      if (r_pend[i]) w_idx = 2'(i);
    w_run = !w_same ? 4'd1 : (w_cur >= SC ? SC : w_cur + 4'd1);
    w_commit = w_hit && w_ok && w_run == SC && (!w_known || w_comm != w_code);
    w_err = w_hit && !w_ok;
    w_load = !r_ovalid || out_ready;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx == 2'(i)) w_lcode = r_comm[i];
      w_launch[i] = w_load && r_pend[i] && w_idx == 2'(i);
      w_cvec[i] = w_commit && r_sel == 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg <= '0;
      r_sel <= '0;
      r_smp <= 1'b0;
      r_cval <= '0;
      r_known <= '0;
      r_pend <= '0;
      r_ovalid <= 1'b0;
      r_oblank <= 1'b0;
      r_odig <= '0;
      r_onib <= '0;
      r_err <= 1'b0;
      r_ecnt <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_cand[i] <= '0;
        r_run[i] <= '0;
        r_comm[i] <= '0;
      end
    end else begin
      r_seg <= seg_in;
      r_sel <= dig_sel;
      r_smp <= sample;
      r_err <= w_err;
      if (w_err && r_ecnt != 8'hff) r_ecnt <= r_ecnt + 8'd1;
      if (w_load) begin
        r_ovalid <= |r_pend;
        if (|r_pend) begin
          r_odig <= w_idx;
          r_onib <= w_lcode[3:0];
          r_oblank <= w_lcode[4];
        end
      end
      // a commit landing on the digit being launched keeps it pending
      r_pend <= (r_pend & ~w_launch) | w_cvec;
      for (int i = 0; i < NUM_DIGITS; i++)
        if (w_hit && r_sel == 2'(i)) begin
          r_cval[i] <= w_ok;
          r_cand[i] <= w_code;
          r_run[i] <= w_ok ? w_run : 4'd0;
          if (w_commit) begin
            r_comm[i] <= w_code;
            r_known[i] <= 1'b1;
          end
        end
    end
  end

  assign out_valid = r_ovalid;
  assign out_digit = r_odig;
  assign out_nibble = r_onib;
  assign out_blank = r_oblank;
  assign digits_flat = w_flat;
  assign err_pulse = r_err;
  assign err_count = r_ecnt;
endmodule
